pipeline_cpu: RTL and testbench
===============================

PIPELINE_CPU -- requirements
Module: pipeline_cpu

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, is the UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, which is 5208 at the defaults.
REQ-003 clk  input  1  single system clock; all flops on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 switch  input  8  user operand; asynchronous to clk.
REQ-006 digi1..digi4  output  7 each  7-segment patterns, active-low, bit order {g,f,e,d,c,b,a}; digi1 is the rightmost digit.
REQ-007 led  output  8  last computed result.
REQ-008 txd  output  1  UART transmit, 8N1, idle high.
REQ-009 rxd  input  1  UART receive, 8N1, idle high; asynchronous to clk.
REQ-010 Port order is clk, reset, switch, digi1, digi2, digi3, digi4, led, txd, rxd.

Function
REQ-011 rxd and switch each pass through a 2-flop synchronizer before use.
REQ-012 RX idle state: a synchronized falling edge starts a frame, and the receiver waits BAUD_DIV/2 clocks.
- If the line is high at that point, it is a glitch: return to idle and produce no byte.
REQ-013 RX data bits: 8 bits, LSB first, each sampled BAUD_DIV clocks after the previous sample; then the stop bit is sampled.
REQ-014 A stop bit of 1 produces a one-cycle rx_valid pulse with the byte.
- A stop bit of 0 is a framing error: the byte is discarded and no pulse is produced.
- In both cases the receiver returns to idle and can accept a new start edge immediately.
REQ-015 Stage 1 registers the byte as A and sets v1 on rx_valid; v1 otherwise clears.
REQ-016 Stage 2 registers A and R = (A + switch_sync) mod 256, with v2 = v1.
REQ-017 Stage 3 registers, only when v2 is set:
- led = R;
- digi4/digi3 = hex glyph of A[7:4]/A[3:0];
- digi2/digi1 = hex glyph of R[7:4]/R[3:0].
These outputs change exactly 3 clocks after the rx_valid pulse and hold otherwise.
REQ-018 Hex glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
REQ-019 In the same cycle as the stage-3 update, R is offered to the transmitter.
REQ-020 TX frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BAUD_DIV clocks.
REQ-021 TX buffering:
- If TX is idle, the new R starts a frame on the next clock.
- If TX is busy, R goes into a one-entry pending buffer, and a newer R overwrites the older one.
- The pending byte starts on the clock after the current stop bit ends.
REQ-022 A new byte arriving while the previous one is still in stages 1-3 is processed normally. The pipeline has no stalls and needs none, since rx_valid pulses are at least 9*BAUD_DIV clocks apart.

Reset
REQ-023 While reset is asserted:
- RX and TX return to idle, with txd=1;
- v1, v2 and the pending-valid flag clear;
- A, R and led become 0;
- all four digits show 40 (glyph "0").
REQ-024 Reset mid-frame aborts the frame in progress with no partial output. After release, RX waits for a new falling edge.

Structure
REQ-025 A shared package pipeline_cpu_pkg holds:
- the CLK_FREQ and BAUD defaults;
- the BAUD_DIV computation;
- the RX/TX state enums (IDLE, START, DATA, STOP);
- the hex-to-glyph function.
REQ-026 uart_rx (synchronizer, glitch check, framing check) is the one sub-module. The 3-stage datapath and the TX FSM live in pipeline_cpu.
REQ-027 Total RTL is 150-300 lines.

Verification
REQ-028 Reset check: assert reset -> txd=1, led=00, digi1..4 all 40.
REQ-029 Single byte: switch=4A, rx byte 01 -> led=4B, digi4=40, digi3=79, digi2=19, digi1=03, exactly 3 clocks after rx_valid; then one txd frame carrying 4B.
REQ-030 Wrap-around: switch=02, rx byte FF -> led=01, digits 0E,0E,40,79 (digi4..digi1), txd frame 01.
REQ-031 Bad frames:
- rxd low for 1000 clocks, then high -> no rx_valid and outputs unchanged;
- a frame with stop bit 0 -> outputs unchanged and no txd frame.
REQ-032 Back-to-back traffic: 10 consecutive frames of 01 with switch=4A -> 10 txd frames of 4B, none lost, txd idle high between frames.
REQ-033 Reset mid-frame: reset halfway through an RX frame and halfway through a TX frame -> txd=1 immediately; the next clean frame is processed correctly.

Source files
------------

// File: rtl/pipeline_cpu_pkg.sv
// Shared constants, UART state encoding and the active-low 7-segment glyph table
// used by the UART receiver and the pipelined adder top level.
package pipeline_cpu_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int DEF_BAUD_DIV = calc_baud_div(DEF_CLK_FREQ, DEF_BAUD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Glyph bit order is {g,f,e,d,c,b,a}, segments lit when 0
  function automatic logic [6:0] hex_glyph(input logic [3:0] i_nib);
    logic [6:0] g;
    case (i_nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, start-bit glitch rejection and stop-bit
// framing check; emits a one-cycle valid pulse per good byte.
module uart_rx
  import pipeline_cpu_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data
);

  localparam int            CW   = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;
  uart_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_valid, w_valid_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + ONE;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_rxd_prev && !r_rxd_sync) w_state_nxt = START;
        else                           w_state_nxt = IDLE;
      end
      START: begin
        // Line back high at mid-start means a glitch, not a frame
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = r_rxd_sync ? IDLE : DATA;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (r_cnt == FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (r_cnt == FULL) begin
          w_state_nxt = IDLE;
          w_valid_nxt = r_rxd_sync;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'h00;
      r_valid    <= 1'b0;
    end else begin
      r_rxd_meta <= i_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign o_rx_valid = r_valid;
  assign o_rx_data  = r_shift;

endmodule

// File: rtl/pipeline_cpu.sv
// Receives bytes over UART, adds the switch operand in a 3-stage pipeline, shows
// operand and result on four 7-segment digits and LEDs, and echoes the result on TX.
module pipeline_cpu
  import pipeline_cpu_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switch,
  output logic [6:0] digi1,
  output logic [6:0] digi2,
  output logic [6:0] digi3,
  output logic [6:0] digi4,
  output logic [7:0] led,
  output logic       txd,
  input  logic       rxd
);

  localparam int            BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int            CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL     = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic [7:0] r_sw_meta, r_sw_sync;
  logic [7:0] r_a1, r_a2, r_r2, r_led;
  logic       r_v1, r_v2;
  logic [6:0] r_digi1, r_digi2, r_digi3, r_digi4;

  uart_state_e   r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic [7:0]    r_pend, w_pend_nxt;
  logic          r_pend_v, w_pend_v_nxt;
  logic          r_txd, w_txd_nxt;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (reset),
    .i_rxd      (rxd),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= 8'h00;
      r_sw_sync <= 8'h00;
      r_a1      <= 8'h00;
      r_v1      <= 1'b0;
      r_a2      <= 8'h00;
      r_r2      <= 8'h00;
      r_v2      <= 1'b0;
      r_led     <= 8'h00;
      r_digi1   <= 7'h40;
      r_digi2   <= 7'h40;
      r_digi3   <= 7'h40;
      r_digi4   <= 7'h40;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      r_v1      <= w_rx_valid;
      if (w_rx_valid) r_a1 <= w_rx_data;
      r_v2      <= r_v1;
      if (r_v1) begin
        r_a2 <= r_a1;
        r_r2 <= r_a1 + r_sw_sync;
      end
      if (r_v2) begin
        r_led   <= r_r2;
        r_digi4 <= hex_glyph(r_a2[7:4]);
        r_digi3 <= hex_glyph(r_a2[3:0]);
        r_digi2 <= hex_glyph(r_r2[7:4]);
        r_digi1 <= hex_glyph(r_r2[3:0]);
      end
    end
  end

  // A fresh result always lands in the pending slot first, so a byte offered in
  // the same cycle a stop bit ends is launched straight away.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + ONE;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_pend_nxt     = r_pend;
    w_pend_v_nxt   = r_pend_v;
    if (r_v2) begin
      w_pend_nxt   = r_r2;
      w_pend_v_nxt = 1'b1;
    end else begin
      w_pend_v_nxt = r_pend_v;
    end
    case (r_tx_state)
      IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_pend_v_nxt) begin
          w_tx_state_nxt = START;
          w_tx_shift_nxt = w_pend_nxt;
          w_pend_v_nxt   = 1'b0;
        end else begin
          w_tx_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_tx_cnt == FULL) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = 3'd0;
          w_tx_state_nxt = DATA;
        end else begin
          w_tx_state_nxt = START;
        end
      end
      DATA: begin
        if (r_tx_cnt == FULL) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = STOP;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          end
        end else begin
          w_tx_state_nxt = DATA;
        end
      end
      STOP: begin
        if (r_tx_cnt == FULL) begin
          w_tx_cnt_nxt = '0;
          if (w_pend_v_nxt) begin
            w_tx_state_nxt = START;
            w_tx_shift_nxt = w_pend_nxt;
            w_pend_v_nxt   = 1'b0;
          end else begin
            w_tx_state_nxt = IDLE;
          end
        end else begin
          w_tx_state_nxt = STOP;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase
    case (w_tx_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_tx_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_pend     <= 8'h00;
      r_pend_v   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  assign led   = r_led;
  assign digi1 = r_digi1;
  assign digi2 = r_digi2;
  assign digi3 = r_digi3;
  assign digi4 = r_digi4;
  assign txd   = r_txd;

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed self-checking bench for pipeline_cpu; runs with a 16-clock bit time and
// decodes txd with an independent UART monitor.
module tb_pipeline_cpu;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switch;
  logic [6:0] digi1, digi2, digi3, digi4;
  logic [7:0] led;
  logic       txd;
  logic       rxd;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rv_cnt    = 0;

  logic [8:0] tx_q[$];
  logic [7:0] mon_d;
  logic       mon_ok;
  logic       mon_stop;

  logic       obs_found;
  logic [7:0] obs_led_n2, obs_led_n3;

  pipeline_cpu #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .reset  (reset),
    .switch (switch),
    .digi1  (digi1),
    .digi2  (digi2),
    .digi3  (digi3),
    .digi4  (digi4),
    .led    (led),
    .txd    (txd),
    .rxd    (rxd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.w_rx_valid === 1'b1) rv_cnt++;
  end

  // Independent TX decoder: samples mid-bit, drops frames cut by reset
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && txd === 1'b0) begin
        mon_ok = 1'b1;
        repeat (DIV / 2) begin
          @(negedge clk);
          if (reset === 1'b1) mon_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) begin
            @(negedge clk);
            if (reset === 1'b1) mon_ok = 1'b0;
          end
          mon_d[b] = txd;
        end
        repeat (DIV) begin
          @(negedge clk);
          if (reset === 1'b1) mon_ok = 1'b0;
        end
        mon_stop = txd;
        if (mon_ok) tx_q.push_back({mon_stop, mon_d});
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rxd = d[b];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Sends a good frame and records led 2 and 3 clocks after the rx_valid pulse
  task automatic run_frame(input logic [7:0] d);
    obs_found  = 1'b0;
    obs_led_n2 = 8'hxx;
    obs_led_n3 = 8'hxx;
    fork
      send_byte(d, 1'b1);
      begin
        for (int i = 0; i < 12 * DIV; i++) begin
          @(negedge clk);
          if (dut.w_rx_valid === 1'b1) begin
            obs_found = 1'b1;
            break;
          end
        end
        if (obs_found) begin
          repeat (2) @(negedge clk);
          obs_led_n2 = led;
          @(negedge clk);
          obs_led_n3 = led;
        end
      end
    join
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 20 * DIV; i++) begin
      if (tx_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    rxd    = 1'b1;
    switch = 8'h00;
    repeat (3) @(negedge clk);
    total_cnt++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else pass_cnt++;
    total_cnt++; if (led !== 8'h00) $display("FAIL reset_led: got %h expected 00", led); else pass_cnt++;
    total_cnt++; if (digi1 !== 7'h40) $display("FAIL reset_digi1: got %h expected 40", digi1); else pass_cnt++;
    total_cnt++; if (digi2 !== 7'h40) $display("FAIL reset_digi2: got %h expected 40", digi2); else pass_cnt++;
    total_cnt++; if (digi3 !== 7'h40) $display("FAIL reset_digi3: got %h expected 40", digi3); else pass_cnt++;
    total_cnt++; if (digi4 !== 7'h40) $display("FAIL reset_digi4: got %h expected 40", digi4); else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    switch = 8'h4A;
    repeat (4) @(negedge clk);
    tx_q.delete();
    run_frame(8'h01);
    total_cnt++; if (obs_found !== 1'b1) $display("FAIL single_rx_valid: got %b expected 1", obs_found); else pass_cnt++;
    total_cnt++; if (obs_led_n2 !== 8'h00) $display("FAIL single_led_2clk: got %h expected 00", obs_led_n2); else pass_cnt++;
    total_cnt++; if (obs_led_n3 !== 8'h4B) $display("FAIL single_led_3clk: got %h expected 4b", obs_led_n3); else pass_cnt++;
    total_cnt++; if (digi4 !== 7'h40) $display("FAIL single_digi4: got %h expected 40", digi4); else pass_cnt++;
    total_cnt++; if (digi3 !== 7'h79) $display("FAIL single_digi3: got %h expected 79", digi3); else pass_cnt++;
    total_cnt++; if (digi2 !== 7'h19) $display("FAIL single_digi2: got %h expected 19", digi2); else pass_cnt++;
    total_cnt++; if (digi1 !== 7'h03) $display("FAIL single_digi1: got %h expected 03", digi1); else pass_cnt++;
    wait_tx(1);
    total_cnt++; if (tx_q.size() !== 1) $display("FAIL single_tx_count: got %0d expected 1", tx_q.size()); else pass_cnt++;
    if (tx_q.size() > 0) begin
      total_cnt++; if (tx_q[0] !== {1'b1, 8'h4B}) $display("FAIL single_tx_frame: got %h expected 14b", tx_q[0]); else pass_cnt++;
    end
    tx_q.delete();
  endtask

  task automatic test_wrap;
    switch = 8'h02;
    repeat (4) @(negedge clk);
    run_frame(8'hFF);
    total_cnt++; if (obs_found !== 1'b1) $display("FAIL wrap_rx_valid: got %b expected 1", obs_found); else pass_cnt++;
    total_cnt++; if (obs_led_n2 !== 8'h4B) $display("FAIL wrap_led_2clk: got %h expected 4b", obs_led_n2); else pass_cnt++;
    total_cnt++; if (obs_led_n3 !== 8'h01) $display("FAIL wrap_led_3clk: got %h expected 01", obs_led_n3); else pass_cnt++;
    total_cnt++; if (digi4 !== 7'h0E) $display("FAIL wrap_digi4: got %h expected 0e", digi4); else pass_cnt++;
    total_cnt++; if (digi3 !== 7'h0E) $display("FAIL wrap_digi3: got %h expected 0e", digi3); else pass_cnt++;
    total_cnt++; if (digi2 !== 7'h40) $display("FAIL wrap_digi2: got %h expected 40", digi2); else pass_cnt++;
    total_cnt++; if (digi1 !== 7'h79) $display("FAIL wrap_digi1: got %h expected 79", digi1); else pass_cnt++;
    wait_tx(1);
    total_cnt++; if (tx_q.size() !== 1) $display("FAIL wrap_tx_count: got %0d expected 1", tx_q.size()); else pass_cnt++;
    if (tx_q.size() > 0) begin
      total_cnt++; if (tx_q[0] !== {1'b1, 8'h01}) $display("FAIL wrap_tx_frame: got %h expected 101", tx_q[0]); else pass_cnt++;
    end
    tx_q.delete();
  endtask

  task automatic test_bad_frames;
    int rv_before;
    rv_before = rv_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    rxd = 1'b0;
    repeat (1000) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    repeat (15 * DIV) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv_before) $display("FAIL bad_rx_valid: got %0d pulses expected 0", rv_cnt - rv_before); else pass_cnt++;
    total_cnt++; if (led !== 8'h01) $display("FAIL bad_led: got %h expected 01", led); else pass_cnt++;
    total_cnt++; if (digi1 !== 7'h79) $display("FAIL bad_digi1: got %h expected 79", digi1); else pass_cnt++;
    total_cnt++; if (tx_q.size() !== 0) $display("FAIL bad_tx_count: got %0d expected 0", tx_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int rv_before;
    switch = 8'h4A;
    repeat (4) @(negedge clk);
    tx_q.delete();
    rv_before = rv_cnt;
    for (int k = 0; k < 10; k++) send_byte(8'h01, 1'b1);
    wait_tx(10);
    repeat (2 * DIV) @(negedge clk);
    total_cnt++; if (rv_cnt - rv_before !== 10) $display("FAIL b2b_rx_count: got %0d expected 10", rv_cnt - rv_before); else pass_cnt++;
    total_cnt++; if (tx_q.size() !== 10) $display("FAIL b2b_tx_count: got %0d expected 10", tx_q.size()); else pass_cnt++;
    for (int k = 0; k < tx_q.size(); k++) begin
      total_cnt++; if (tx_q[k] !== {1'b1, 8'h4B}) $display("FAIL b2b_tx_frame%0d: got %h expected 14b", k, tx_q[k]); else pass_cnt++;
    end
    total_cnt++; if (txd !== 1'b1) $display("FAIL b2b_txd_idle: got %b expected 1", txd); else pass_cnt++;
    tx_q.delete();
  endtask

  task automatic test_reset_mid;
    int   rv_before;
    logic txd_pre;
    rv_before = rv_cnt;
    fork
      send_byte(8'h01, 1'b1);
      begin
        repeat (5 * DIV) @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    total_cnt++; if (led !== 8'h00) $display("FAIL rxmid_led: got %h expected 00", led); else pass_cnt++;
    total_cnt++; if (digi4 !== 7'h40) $display("FAIL rxmid_digi4: got %h expected 40", digi4); else pass_cnt++;
    reset = 1'b0;
    repeat (15 * DIV) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv_before) $display("FAIL rxmid_no_byte: got %0d pulses expected 0", rv_cnt - rv_before); else pass_cnt++;

    run_frame(8'h01);
    repeat (2) @(negedge clk);
    txd_pre = txd;
    total_cnt++; if (txd_pre !== 1'b0) $display("FAIL txmid_start_bit: got %b expected 0", txd_pre); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (txd !== 1'b1) $display("FAIL txmid_txd: got %b expected 1", txd); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    tx_q.delete();

    run_frame(8'h01);
    total_cnt++; if (obs_led_n2 !== 8'h00) $display("FAIL after_led_2clk: got %h expected 00", obs_led_n2); else pass_cnt++;
    total_cnt++; if (obs_led_n3 !== 8'h4B) $display("FAIL after_led_3clk: got %h expected 4b", obs_led_n3); else pass_cnt++;
    wait_tx(1);
    total_cnt++; if (tx_q.size() !== 1) $display("FAIL after_tx_count: got %0d expected 1", tx_q.size()); else pass_cnt++;
    if (tx_q.size() > 0) begin
      total_cnt++; if (tx_q[0] !== {1'b1, 8'h4B}) $display("FAIL after_tx_frame: got %h expected 14b", tx_q[0]); else pass_cnt++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    rxd    = 1'b1;
    switch = 8'h00;
    test_reset();
    test_single();
    test_wrap();
    test_bad_frames();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
